// File: rtl/pong_game_ctrl_if.sv
// Ball datapath link for the pong game controller: move/serve commands out,
// wall-miss and paddle-hit events back.
interface pong_game_ctrl_if;
  logic       miss_l;
  logic       miss_r;
  logic       paddle_hit;
  logic       animate;
  logic       ball_rst;
  logic       serve_dir;
  logic [2:0] speed;

  modport master (
    input  miss_l, miss_r, paddle_hit,
    output animate, ball_rst, serve_dir, speed
  );

  modport slave (
    output miss_l, miss_r, paddle_hit,
    input  animate, ball_rst, serve_dir, speed
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: frame tick, serve/play/point/pause/game-over FSM, scoring and speed.
// Optional build macro PONG_ATTRACT_EN: ball animates as a demo while IDLE.
module pong_game_ctrl #(
  parameter int FRAME_LINE    = 524,
  parameter int SERVE_FRAMES  = 60,
  parameter int POINT_FRAMES  = 30,
  parameter int WIN_SCORE     = 7,
  parameter int SPEED_INIT    = 1,
  parameter int SPEED_MAX     = 4,
  parameter int HITS_PER_STEP = 4
) (
  input  logic             clk_25,
  input  logic             rst,
  input  logic [9:0]       sx,
  input  logic [9:0]       sy,
  input  logic             btn_start,
  input  logic             btn_pause,
  pong_game_ctrl_if.master ball,
  output logic [3:0]       score_l,
  output logic [3:0]       score_r,
  output logic [2:0]       state,
  output logic             winner
);

  localparam int FC_W  = 16;
  localparam int HIT_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    POINT    = 3'd3,
    PAUSE    = 3'd4,
    GAMEOVER = 3'd5
  } state_e;

  state_e            state_q;
  logic              tick_q;
  logic              start_q;
  logic              pause_q;
  logic              animate_q;
  logic              ball_rst_q;
  logic              serve_dir_q;
  logic [2:0]        speed_q;
  logic [3:0]        score_l_q;
  logic [3:0]        score_r_q;
  logic              winner_q;
  logic [FC_W-1:0]   frame_q;
  logic [HIT_W-1:0]  hit_q;

  logic tick_d;
  logic start_edge_d;
  logic pause_edge_d;

  function automatic logic [3:0] score_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  function automatic logic [2:0] speed_step(input logic [2:0] v);
    return (v >= 3'(SPEED_MAX)) ? 3'(SPEED_MAX) : v + 3'd1;
  endfunction

  assign tick_d       = (sy == 10'(FRAME_LINE)) && (sx == 10'd0);
  assign start_edge_d = btn_start & ~start_q;
  assign pause_edge_d = btn_pause & ~pause_q;

  always_ff @(posedge clk_25) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_q      <= 1'b0;
      start_q     <= 1'b0;
      pause_q     <= 1'b0;
      animate_q   <= 1'b0;
      ball_rst_q  <= 1'b0;
      serve_dir_q <= 1'b0;
      speed_q     <= 3'(SPEED_INIT);
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      winner_q    <= 1'b0;
      frame_q     <= '0;
      hit_q       <= '0;
    end else begin
      tick_q     <= tick_d;
      start_q    <= btn_start;
      pause_q    <= btn_pause;
      animate_q  <= 1'b0;
      ball_rst_q <= 1'b0;

      unique case (state_q)
        IDLE, GAMEOVER: begin
`ifdef PONG_ATTRACT_EN
          // Demo ball: moves and recentres on misses, never scores.
          if (state_q == IDLE) begin
            animate_q <= tick_d;
            if (ball.miss_l || ball.miss_r) begin
              ball_rst_q  <= 1'b1;
              serve_dir_q <= ~serve_dir_q;
            end
          end
`endif
          if (start_edge_d) begin
            score_l_q  <= 4'd0;
            score_r_q  <= 4'd0;
            speed_q    <= 3'(SPEED_INIT);
            hit_q      <= '0;
            ball_rst_q <= 1'b1;
            frame_q    <= '0;
            state_q    <= SERVE;
          end
        end

        SERVE: begin
          if (tick_q) begin
            if (frame_q == FC_W'(SERVE_FRAMES - 1)) begin
              frame_q <= '0;
              state_q <= PLAY;
            end else begin
              frame_q <= frame_q + 1'b1;
            end
          end
        end

        PLAY: begin
          animate_q <= tick_d;
          // A miss outranks a hit or pause in the same cycle; a double miss replays the point.
          if (ball.miss_l || ball.miss_r) begin
            frame_q <= '0;
            state_q <= POINT;
            if (ball.miss_l && !ball.miss_r) begin
              score_r_q   <= score_inc(score_r_q);
              serve_dir_q <= 1'b0;
            end else if (ball.miss_r && !ball.miss_l) begin
              score_l_q   <= score_inc(score_l_q);
              serve_dir_q <= 1'b1;
            end
          end else begin
            if (ball.paddle_hit) begin
              if (hit_q == HIT_W'(HITS_PER_STEP - 1)) begin
                hit_q   <= '0;
                speed_q <= speed_step(speed_q);
              end else begin
                hit_q <= hit_q + 1'b1;
              end
            end
            if (pause_edge_d) begin
              frame_q <= '0;
              state_q <= PAUSE;
            end
          end
        end

        POINT: begin
          if (tick_q) begin
            if (frame_q == FC_W'(POINT_FRAMES - 1)) begin
              frame_q <= '0;
              if ((score_l_q == 4'(WIN_SCORE)) || (score_r_q == 4'(WIN_SCORE))) begin
                winner_q <= (score_r_q == 4'(WIN_SCORE));
                state_q  <= GAMEOVER;
              end else begin
                ball_rst_q <= 1'b1;
                speed_q    <= 3'(SPEED_INIT);
                hit_q      <= '0;
                state_q    <= SERVE;
              end
            end else begin
              frame_q <= frame_q + 1'b1;
            end
          end
        end

        PAUSE: begin
          if (pause_edge_d) begin
            frame_q <= '0;
            state_q <= PLAY;
          end
        end

        default: begin
          frame_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ball.animate   = animate_q;
  assign ball.ball_rst  = ball_rst_q;
  assign ball.serve_dir = serve_dir_q;
  assign ball.speed     = speed_q;
  assign score_l        = score_l_q;
  assign score_r        = score_r_q;
  assign state          = state_q;
  assign winner         = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl (default build, attract mode off).
module tb_pong_game_ctrl;
  localparam int FRAME_LINE = 524;

  logic       clk_25 = 1'b0;
  logic       rst;
  logic [9:0] sx, sy;
  logic       btn_start, btn_pause;
  logic [3:0] score_l, score_r;
  logic [2:0] state;
  logic       winner;

  int checks = 0;
  int passes = 0;

  pong_game_ctrl_if ball_if ();

  pong_game_ctrl dut (
    .clk_25   (clk_25),
    .rst      (rst),
    .sx       (sx),
    .sy       (sy),
    .btn_start(btn_start),
    .btn_pause(btn_pause),
    .ball     (ball_if),
    .score_l  (score_l),
    .score_r  (score_r),
    .state    (state),
    .winner   (winner)
  );

  always #5 clk_25 = ~clk_25;

  // One short synthetic frame: the scan hits (FRAME_LINE, 0) once, then idles for 3 cycles.
  task automatic run_frames(input int n, output int na, output int nb, output int first_anim);
    na = 0; nb = 0; first_anim = -1;
    for (int f = 0; f < n; f++) begin
      sx = 10'd0; sy = 10'(FRAME_LINE);
      for (int i = 0; i < 4; i++) begin
        @(posedge clk_25); #1;
        if (i == 0) begin sx = 10'd5; sy = 10'd0; end
        if (ball_if.animate) begin
          na++;
          if (first_anim < 0) first_anim = i;
        end
        if (ball_if.ball_rst) nb++;
      end
    end
  endtask

  task automatic pulse(input logic ml, input logic mr, input logic ph);
    ball_if.miss_l = ml; ball_if.miss_r = mr; ball_if.paddle_hit = ph;
    @(posedge clk_25); #1;
    ball_if.miss_l = 1'b0; ball_if.miss_r = 1'b0; ball_if.paddle_hit = 1'b0;
  endtask

  task automatic press(input logic st, input logic pa);
    btn_start = st; btn_pause = pa;
    @(posedge clk_25); #1;
  endtask

  task automatic release_btns();
    btn_start = 1'b0; btn_pause = 1'b0;
    @(posedge clk_25); #1;
  endtask

  task automatic test_reset();
    int na, nb, fa;
    rst = 1'b1;
    repeat (2) @(posedge clk_25);
    #1; rst = 1'b0;
    checks++; if (state !== 3'd0) $display("FAIL reset_state got %0d want 0", state); else passes++;
    checks++; if (ball_if.animate !== 1'b0) $display("FAIL reset_animate got %b want 0", ball_if.animate); else passes++;
    checks++; if (ball_if.ball_rst !== 1'b0) $display("FAIL reset_ball_rst got %b want 0", ball_if.ball_rst); else passes++;
    checks++; if (ball_if.speed !== 3'd1) $display("FAIL reset_speed got %0d want 1", ball_if.speed); else passes++;
    checks++; if ({score_l, score_r} !== 8'h00) $display("FAIL reset_scores got %0d/%0d want 0/0", score_l, score_r); else passes++;
    checks++; if ({winner, ball_if.serve_dir} !== 2'b00) $display("FAIL reset_win_dir got %b%b want 00", winner, ball_if.serve_dir); else passes++;
    run_frames(3, na, nb, fa);
    checks++; if (na !== 0) $display("FAIL idle_animate got %0d want 0", na); else passes++;
    checks++; if (state !== 3'd0) $display("FAIL idle_state got %0d want 0", state); else passes++;
  endtask

  task automatic test_start();
    int na, nb, fa, tot;
    press(1'b1, 1'b0);
    checks++; if (ball_if.ball_rst !== 1'b1) $display("FAIL start_ball_rst got %b want 1", ball_if.ball_rst); else passes++;
    checks++; if (state !== 3'd1) $display("FAIL start_state got %0d want 1", state); else passes++;
    release_btns();
    checks++; if (ball_if.ball_rst !== 1'b0) $display("FAIL start_ball_rst_len got %b want 0", ball_if.ball_rst); else passes++;
    run_frames(59, na, nb, fa);
    tot = na;
    checks++; if (state !== 3'd1) $display("FAIL serve_hold got %0d want 1", state); else passes++;
    run_frames(1, na, nb, fa);
    tot += na;
    checks++; if (state !== 3'd2) $display("FAIL serve_to_play got %0d want 2", state); else passes++;
    checks++; if (tot !== 0) $display("FAIL serve_animate got %0d want 0", tot); else passes++;
    run_frames(3, na, nb, fa);
    checks++; if (na !== 3) $display("FAIL play_animate_count got %0d want 3", na); else passes++;
    checks++; if (fa !== 0) $display("FAIL play_animate_phase got %0d want 0", fa); else passes++;
  endtask

  task automatic test_speed();
    for (int i = 1; i <= 16; i++) begin
      pulse(1'b0, 1'b0, 1'b1);
      if (i == 3) begin
        checks++; if (ball_if.speed !== 3'd1) $display("FAIL speed_3hits got %0d want 1", ball_if.speed); else passes++;
      end
      if (i == 4) begin
        checks++; if (ball_if.speed !== 3'd2) $display("FAIL speed_4hits got %0d want 2", ball_if.speed); else passes++;
      end
      if (i == 9) begin
        checks++; if (ball_if.speed !== 3'd3) $display("FAIL speed_9hits got %0d want 3", ball_if.speed); else passes++;
      end
      if (i == 16) begin
        checks++; if (ball_if.speed !== 3'd4) $display("FAIL speed_sat got %0d want 4", ball_if.speed); else passes++;
      end
    end
  endtask

  task automatic test_point();
    int na, nb, fa;
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if (state !== 3'd3) $display("FAIL miss_l_state got %0d want 3", state); else passes++;
    checks++; if ({score_l, score_r} !== 8'h01) $display("FAIL miss_l_score got %0d/%0d want 0/1", score_l, score_r); else passes++;
    checks++; if (ball_if.serve_dir !== 1'b0) $display("FAIL miss_l_dir got %b want 0", ball_if.serve_dir); else passes++;
    run_frames(29, na, nb, fa);
    checks++; if (state !== 3'd3 || na !== 0 || nb !== 0) $display("FAIL point_hold got st%0d a%0d r%0d want st3 a0 r0", state, na, nb); else passes++;
    run_frames(1, na, nb, fa);
    checks++; if (nb !== 1) $display("FAIL point_ball_rst got %0d want 1", nb); else passes++;
    checks++; if (state !== 3'd1) $display("FAIL point_to_serve got %0d want 1", state); else passes++;
    checks++; if (ball_if.speed !== 3'd1) $display("FAIL point_speed got %0d want 1", ball_if.speed); else passes++;
    run_frames(60, na, nb, fa);
    checks++; if (state !== 3'd2) $display("FAIL reserve_play got %0d want 2", state); else passes++;
  endtask

  task automatic test_double_miss();
    int na, nb, fa;
    pulse(1'b1, 1'b1, 1'b0);
    checks++; if (state !== 3'd3) $display("FAIL dbl_state got %0d want 3", state); else passes++;
    checks++; if ({score_l, score_r, 3'b000, ball_if.serve_dir} !== 12'h010) $display("FAIL dbl_score got %0d/%0d dir%b want 0/1 dir0", score_l, score_r, ball_if.serve_dir); else passes++;
    run_frames(90, na, nb, fa);
    checks++; if (state !== 3'd2) $display("FAIL dbl_back_to_play got %0d want 2", state); else passes++;
  endtask

  task automatic test_pause();
    int na, nb, fa;
    press(1'b0, 1'b1);
    checks++; if (state !== 3'd4) $display("FAIL pause_enter got %0d want 4", state); else passes++;
    release_btns();
    run_frames(2, na, nb, fa);
    checks++; if (na !== 0 || state !== 3'd4) $display("FAIL pause_hold got a%0d st%0d want a0 st4", na, state); else passes++;
    press(1'b1, 1'b0);
    checks++; if (state !== 3'd4 || ball_if.ball_rst !== 1'b0) $display("FAIL pause_start_ignored got st%0d r%b want st4 r0", state, ball_if.ball_rst); else passes++;
    release_btns();
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if (score_r !== 4'd1 || state !== 3'd4) $display("FAIL pause_miss_ignored got r%0d st%0d want r1 st4", score_r, state); else passes++;
    press(1'b0, 1'b1);
    checks++; if (state !== 3'd2) $display("FAIL pause_exit got %0d want 2", state); else passes++;
    release_btns();
    run_frames(1, na, nb, fa);
    checks++; if (na !== 1) $display("FAIL resume_animate got %0d want 1", na); else passes++;
  endtask

  task automatic test_miss_priority();
    int na, nb, fa;
    btn_pause = 1'b1;
    pulse(1'b0, 1'b1, 1'b1);
    checks++; if (state !== 3'd3) $display("FAIL prio_state got %0d want 3", state); else passes++;
    checks++; if (score_l !== 4'd1 || ball_if.serve_dir !== 1'b1) $display("FAIL prio_score got l%0d dir%b want l1 dir1", score_l, ball_if.serve_dir); else passes++;
    release_btns();
    run_frames(90, na, nb, fa);
    checks++; if (state !== 3'd2) $display("FAIL prio_back_to_play got %0d want 2", state); else passes++;
  endtask

  task automatic test_gameover();
    int na, nb, fa;
    for (int k = 2; k <= 7; k++) begin
      pulse(1'b0, 1'b1, 1'b0);
      checks++; if (score_l !== 4'(k)) $display("FAIL go_score got %0d want %0d", score_l, k); else passes++;
      run_frames(30, na, nb, fa);
      if (k < 7) begin
        checks++; if (state !== 3'd1 || nb !== 1) $display("FAIL go_reserve got st%0d r%0d want st1 r1", state, nb); else passes++;
        run_frames(60, na, nb, fa);
      end else begin
        checks++; if (state !== 3'd5) $display("FAIL go_state got %0d want 5", state); else passes++;
        checks++; if (winner !== 1'b0 || nb !== 0) $display("FAIL go_winner got w%b r%0d want w0 r0", winner, nb); else passes++;
      end
    end
    run_frames(2, na, nb, fa);
    checks++; if ({score_l, score_r} !== 8'h71 || state !== 3'd5) $display("FAIL go_hold got %0d/%0d st%0d want 7/1 st5", score_l, score_r, state); else passes++;
    press(1'b1, 1'b0);
    checks++; if (state !== 3'd1 || ball_if.ball_rst !== 1'b1) $display("FAIL go_restart got st%0d r%b want st1 r1", state, ball_if.ball_rst); else passes++;
    checks++; if ({score_l, score_r} !== 8'h00) $display("FAIL go_clear got %0d/%0d want 0/0", score_l, score_r); else passes++;
    release_btns();
  endtask

  initial begin
    rst = 1'b1; sx = 10'd5; sy = 10'd0;
    btn_start = 1'b0; btn_pause = 1'b0;
    ball_if.miss_l = 1'b0; ball_if.miss_r = 1'b0; ball_if.paddle_hit = 1'b0;
    test_reset();
    test_start();
    test_speed();
    test_point();
    test_double_miss();
    test_pause();
    test_miss_priority();
    test_gameover();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
